// File: rtl/motors_pkg.sv
// Shared definitions for the navigation FSM and the motor driver.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package motors_pkg;

    // Navigation state encoding; the motor driver may decode these directly.
    typedef enum logic [2:0] {
        ST_PARK   = 3'd0,
        ST_FWD    = 3'd1,
        ST_STOP   = 3'd2,
        ST_BACK   = 3'd3,
        ST_TURN_L = 3'd4,
        ST_TURN_R = 3'd5,
        ST_HALT   = 3'd6
    } nav_state_t;

    // One-hot motor commands.
    localparam logic [4:0] DIR_FORWARD  = 5'b00001;
    localparam logic [4:0] DIR_IDLE     = 5'b00010;
    localparam logic [4:0] DIR_BACKWARD = 5'b00100;
    localparam logic [4:0] DIR_LEFT     = 5'b01000;
    localparam logic [4:0] DIR_RIGHT    = 5'b10000;

    // Turn-side flag values used in alternating mode.
    localparam logic SIDE_RIGHT = 1'b0;
    localparam logic SIDE_LEFT  = 1'b1;

    // Motor command is a pure function of the state.
    function automatic logic [4:0] dir_of_state(input nav_state_t s);
        logic [4:0] d;
        case (s)
            ST_FWD:    d = DIR_FORWARD;
            ST_BACK:   d = DIR_BACKWARD;
            ST_TURN_L: d = DIR_LEFT;
            ST_TURN_R: d = DIR_RIGHT;
            default:   d = DIR_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/nav_timer.sv
// Loadable down-counter; expire is high while the count is zero.
// Latency: load takes effect on the next clkin edge; expire is combinational from the count.
// Backpressure: none. Ports: clkin, reset (async active-low), load, load_val in; expire out.
module nav_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Load wins over counting; the count parks at zero until reloaded.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/motors_nav_fsm.sv
// Obstacle-avoidance navigation FSM: forward, stop, back off, turn, retry, halt on too many retries.
// Latency: outputs are registered-state decodes; input changes act on the next clkin edge.
// Backpressure: none. Ports: clkin, reset (async active-low), enable, obstacle, clear_fault in; direction[4:0], retries[3:0], fault out.
module motors_nav_fsm
    import motors_pkg::*;
#(
    parameter int STOP_CYCLES = 4,
    parameter int BACK_CYCLES = 8,
    parameter int TURN_CYCLES = 8,
    parameter int MAX_RETRIES = 3,
    parameter int TURN_MODE   = 0,
    parameter int TIMER_W     = 16
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       enable,
    input  logic       obstacle,
    input  logic       clear_fault,
    output logic [4:0] direction,
    output logic [3:0] retries,
    output logic       fault
);

    localparam logic [TIMER_W-1:0] STOP_LOAD = TIMER_W'(STOP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BACK_LOAD = TIMER_W'(BACK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES - 1);
    localparam logic [3:0]         RETRY_MAX = 4'(MAX_RETRIES);

    nav_state_t         state_q, state_d;
    logic [3:0]         retries_q, retries_d;
    logic               side_q, side_d;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_expire;
    logic [3:0]         retries_inc;
    logic               turn_right;

    nav_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clkin    (clkin),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Saturating increment of the attempt counter.
    assign retries_inc = (retries_q >= RETRY_MAX) ? RETRY_MAX : retries_q + 4'd1;
    // Fixed-right mode ignores the side flag entirely.
    assign turn_right  = (TURN_MODE == 0) || (side_q == SIDE_RIGHT);

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        side_d    = side_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        if (state_q == ST_HALT) begin
            // HALT outranks enable: only clear_fault gets out.
            if (clear_fault) begin
                state_d   = ST_PARK;
                retries_d = 4'd0;
            end
        end else if (!enable) begin
            // Parking abandons any running timer; it is reloaded on the next timed entry.
            state_d = ST_PARK;
        end else begin
            case (state_q)
                ST_PARK: begin
                    state_d   = ST_FWD;
                    retries_d = 4'd0;
                end
                ST_FWD: begin
                    if (obstacle) begin
                        state_d  = ST_STOP;
                        tmr_load = 1'b1;
                        tmr_val  = STOP_LOAD;
                    end
                end
                ST_STOP: begin
                    if (!obstacle) begin
                        state_d   = ST_FWD;
                        retries_d = 4'd0;
                    end else if (tmr_expire) begin
                        state_d  = ST_BACK;
                        tmr_load = 1'b1;
                        tmr_val  = BACK_LOAD;
                    end
                end
                ST_BACK: begin
                    if (tmr_expire) begin
                        state_d  = turn_right ? ST_TURN_R : ST_TURN_L;
                        tmr_load = 1'b1;
                        tmr_val  = TURN_LOAD;
                        if (TURN_MODE != 0) begin
                            side_d = ~side_q;
                        end
                    end
                end
                ST_TURN_L, ST_TURN_R: begin
                    if (tmr_expire) begin
                        if (!obstacle) begin
                            state_d   = ST_FWD;
                            retries_d = 4'd0;
                        end else begin
                            retries_d = retries_inc;
                            if (retries_inc == RETRY_MAX) begin
                                state_d = ST_HALT;
                            end else begin
                                state_d  = ST_BACK;
                                tmr_load = 1'b1;
                                tmr_val  = BACK_LOAD;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_PARK;
                end
            endcase
        end
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PARK;
            retries_q <= 4'd0;
            side_q    <= SIDE_RIGHT;
        end else begin
            state_q   <= state_d;
            retries_q <= retries_d;
            side_q    <= side_d;
        end
    end

    assign direction = dir_of_state(state_q);
    assign retries   = retries_q;
    assign fault     = (state_q == ST_HALT);

endmodule
